// File: rtl/wgt_pkg.sv
// Shared types and constants for the weight
// streaming engine.
package wgt_pkg;

  localparam int WGT_W   = 8;
  localparam int TAP_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    FETCH,
    DRAIN,
    FIN
  } state_t;

endpackage

// File: rtl/wgt_rd_pipe.sv
// Two-stage valid/data register between the
// weight SRAM and the shift-buffer chain.
module wgt_rd_pipe
  import wgt_pkg::*;
(
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    en_i,
  input  logic signed [WGT_W-1:0] rdata_i,
  output logic                    vld_o,
  output logic signed [WGT_W-1:0] wgt_o
);

  logic                    rd_v_q;
  logic                    vld_q;
  logic signed [WGT_W-1:0] wgt_q;

  // Track the SRAM latency, then latch data as it arrives.
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_v_q <= 1'b0;
      vld_q  <= 1'b0;
      wgt_q  <= '0;
    end else begin
      rd_v_q <= en_i;
      vld_q  <= rd_v_q;
      if (rd_v_q) wgt_q <= rdata_i;
    end
  end

  assign vld_o = vld_q;
  assign wgt_o = wgt_q;

endmodule

// File: rtl/wgt_feeder.sv
// Weight feeder: fetches TAP-word groups from
// SRAM and streams them into the shift buffers.
module wgt_feeder
  import wgt_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int TAP    = TAP_DEF,
  parameter int GRP_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [GRP_W-1:0]        num_groups,
  input  logic                    ready_in,
  output logic                    mem_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic signed [WGT_W-1:0] mem_rdata,
  output logic signed [WGT_W-1:0] wgt_out,
  output logic                    wgt_read,
  output logic                    group_done,
  output logic                    busy,
  output logic                    done
);

  localparam int TW = (TAP > 1) ? $clog2(TAP) : 1;
  localparam logic [TW-1:0] TAP_LAST = TW'(TAP - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TW-1:0]     tap_q, tap_d;
  logic [GRP_W-1:0]  grp_q, grp_d;
  logic [GRP_W-1:0]  ngrp_q, ngrp_d;
  logic              drn_q, drn_d;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      tap_q   <= '0;
      grp_q   <= '0;
      ngrp_q  <= '0;
      drn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tap_q   <= tap_d;
      grp_q   <= grp_d;
      ngrp_q  <= ngrp_d;
      drn_q   <= drn_d;
    end
  end

  // Sequencing: wait, fetch one group, drain, repeat.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tap_d   = tap_q;
    grp_d   = grp_q;
    ngrp_d  = ngrp_q;
    drn_d   = drn_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num_groups != '0) begin
            addr_d  = base_addr;
            ngrp_d  = num_groups;
            tap_d   = '0;
            grp_d   = '0;
            state_d = WAIT;
          end else begin
            state_d = FIN;
          end
        end
      end
      WAIT: begin
        if (ready_in) state_d = FETCH;
      end
      FETCH: begin
        addr_d = addr_q + ADDR_W'(1);
        tap_d  = tap_q + TW'(1);
        if (tap_q == TAP_LAST) begin
          tap_d   = '0;
          grp_d   = grp_q + GRP_W'(1);
          drn_d   = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        drn_d = 1'b1;
        if (drn_q) begin
          drn_d   = 1'b0;
          state_d = (grp_q == ngrp_q) ? FIN : WAIT;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  wgt_rd_pipe u_pipe (
    .clk     (clk),
    .clr     (rst),
    .en_i    (mem_en),
    .rdata_i (mem_rdata),
    .vld_o   (wgt_read),
    .wgt_o   (wgt_out)
  );

  assign mem_en     = (state_q == FETCH);
  assign mem_addr   = addr_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign group_done = wgt_read & drn_q &
                      (state_q == DRAIN);

endmodule

// File: tb/tb_wgt_feeder.sv
// Directed bench for wgt_feeder with an SRAM
// model and a queue-based expectation model.
module tb_wgt_feeder;

  localparam int AW  = 10;
  localparam int TAP = 4;
  localparam int GW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ready_in = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [GW-1:0] num_groups = '0;
  logic mem_en;
  logic [AW-1:0] mem_addr;
  logic signed [7:0] mem_rdata;
  logic signed [7:0] wgt_out;
  logic wgt_read, group_done, busy, done;

  always #5 clk = ~clk;

  int vec = 0;
  int miss = 0;
  int cyc = 0;
  int c0 = 0;
  int en_cnt = 0;
  int busy_cnt = 0;
  int rcnt = 0;
  int sbuf[TAP];
  logic [7:0] sram [1024];
  logic signed [7:0] rdata_q = '0;
  int eaddr[$], ewgt[$];
  int rd_log[$], gd_log[$], done_log[$];
  int addr_log[$], wv_log[$];

  wgt_feeder #(
    .ADDR_W (AW),
    .TAP    (TAP),
    .GRP_W  (GW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .num_groups (num_groups),
    .ready_in   (ready_in),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .wgt_out    (wgt_out),
    .wgt_read   (wgt_read),
    .group_done (group_done),
    .busy       (busy),
    .done       (done)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) rdata_q <= sram[mem_addr];
  end
  assign mem_rdata = rdata_q;

  task automatic chk(string nm, int act, int exp);
    vec++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d, want %0d",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_logs();
    rd_log.delete();
    gd_log.delete();
    done_log.delete();
    addr_log.delete();
    wv_log.delete();
    en_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic model(int b, int n);
    int a;
    for (int g = 0; g < n; g++)
      for (int k = 0; k < TAP; k++) begin
        a = (b + g * TAP + k) % 1024;
        eaddr.push_back(a);
        ewgt.push_back(int'($signed(sram[a])));
      end
  endtask

  task automatic go(int b, int n);
    base_addr  = AW'(b);
    num_groups = GW'(n);
    start = 1'b1;
    c0 = cyc;
    model(b, n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(int lim);
    int i;
    i = 0;
    while (!done && i < lim) begin
      tick();
      i++;
    end
    if (!done) chk("done_timeout", 0, 1);
    tick();
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_mem_en"}, int'(mem_en), 0);
    chk({nm, "_mem_addr"}, int'(mem_addr), 0);
    chk({nm, "_wgt_read"}, int'(wgt_read), 0);
    chk({nm, "_wgt_out"}, int'(wgt_out), 0);
    chk({nm, "_gdone"}, int'(group_done), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      rcnt = 0;
    end else begin
      if (mem_en) begin
        en_cnt++;
        addr_log.push_back(int'(mem_addr));
        if (eaddr.size() == 0)
          chk("extra_mem_en", 1, 0);
        else
          chk("mem_addr", int'(mem_addr),
              eaddr.pop_front());
      end
      if (wgt_read) begin
        rd_log.push_back(cyc - c0);
        wv_log.push_back(int'(wgt_out));
        if (ewgt.size() == 0)
          chk("extra_wgt_read", 1, 0);
        else
          chk("wgt_out", int'(wgt_out),
              ewgt.pop_front());
        chk("group_done", int'(group_done),
            int'(rcnt == TAP - 1));
        for (int i = TAP - 1; i > 0; i--)
          sbuf[i] = sbuf[i-1];
        sbuf[0] = int'(wgt_out);
        rcnt = (rcnt + 1) % TAP;
      end else begin
        chk("gdone_idle", int'(group_done), 0);
      end
      if (group_done) gd_log.push_back(cyc - c0);
      if (done) done_log.push_back(cyc - c0);
      if (busy) busy_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int i;
    for (int a = 0; a < 1024; a++)
      sram[a] = 8'(a - 16);
    sram[256] = 8'h80;
    sram[257] = 8'hFF;
    sram[258] = 8'h7F;
    sram[259] = 8'h01;

    rst = 1'b1;
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;

    ready_in = 1'b1;
    clr_logs();
    go(16, 1);
    wait_done(30);
    chk("t1_nrd", rd_log.size(), 4);
    chk("t1_rd_first", rd_log[0], 4);
    chk("t1_rd_last", rd_log[3], 7);
    chk("t1_gd_cyc", gd_log[0], 7);
    chk("t1_done_cyc", done_log[0], 8);
    for (int k = 0; k < 4; k++)
      chk("t1_wgt", wv_log[k], k);
    chk("t1_slot3", sbuf[3], 0);
    chk("t1_slot2", sbuf[2], 1);
    chk("t1_slot1", sbuf[1], 2);
    chk("t1_slot0", sbuf[0], 3);

    ready_in = 1'b0;
    clr_logs();
    go(16, 3);
    for (int g = 0; g < 3; g++) begin
      for (int j = 0; j < 5; j++) begin
        chk("t2_wait_mem_en", int'(mem_en), 0);
        tick();
      end
      ready_in = 1'b1;
      tick();
      ready_in = 1'b0;
      i = 0;
      while (!group_done && i < 20) begin
        tick();
        i++;
      end
      chk("t2_gd_seen", int'(group_done), 1);
      tick();
    end
    wait_done(10);
    chk("t2_nrd", rd_log.size(), 12);
    chk("t2_ngd", gd_log.size(), 3);
    chk("t2_nen", en_cnt, 12);
    chk("t2_addr_first", addr_log[0], 16);
    chk("t2_addr_last", addr_log[11], 27);
    chk("t2_ndone", done_log.size(), 1);

    ready_in = 1'b1;
    clr_logs();
    go(1022, 1);
    wait_done(30);
    chk("t3_a0", addr_log[0], 1022);
    chk("t3_a1", addr_log[1], 1023);
    chk("t3_a2", addr_log[2], 0);
    chk("t3_a3", addr_log[3], 1);

    clr_logs();
    go(256, 1);
    wait_done(30);
    chk("t4_w0", wv_log[0], -128);
    chk("t4_w1", wv_log[1], -1);
    chk("t4_w2", wv_log[2], 127);
    chk("t4_w3", wv_log[3], 1);

    clr_logs();
    go(80, 0);
    chk("t5_done_now", int'(done), 1);
    wait_done(5);
    chk("t5_done_cyc", done_log[0], 1);
    chk("t5_busy_cyc", busy_cnt, 1);
    chk("t5_nen", en_cnt, 0);

    clr_logs();
    go(32, 1);
    tick();
    base_addr  = AW'(512);
    num_groups = GW'(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(30);
    tick();
    tick();
    chk("t6_nen", en_cnt, 4);
    chk("t6_nrd", rd_log.size(), 4);
    chk("t6_busy", int'(busy), 0);
    chk("t6_left", eaddr.size(), 0);

    clr_logs();
    go(48, 1);
    tick();
    rst = 1'b1;
    tick();
    chk_zero("t7_abort");
    rst = 1'b0;
    eaddr.delete();
    ewgt.delete();
    for (int j = 0; j < 5; j++) tick();
    chk("t7_no_done", done_log.size(), 0);
    chk("t7_no_gd", gd_log.size(), 0);
    chk("t7_no_rd", rd_log.size(), 0);
    clr_logs();
    go(48, 1);
    wait_done(30);
    chk("t7_nrd", rd_log.size(), 4);
    chk("t7_ndone", done_log.size(), 1);
    chk("t7_w0", wv_log[0], 32);
    chk("t7_left", ewgt.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end

endmodule
